alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised successor to the team's 4-bit, 16-instruction ALU.
- WIDTH-generic datapath with valid/ready handshakes on input and output, a registered result with status flags, and a multi-cycle shift-add multiplier that returns the full 2*WIDTH product.
- Sits between an instruction-issue stage and a writeback/consumer stage.

Parameters:
- WIDTH, 4, operand/result width in bits (legal range 2 to 32)
- CNT_W, $clog2(WIDTH)+1, multiplier iteration counter width (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands and instruction valid
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- instruction  input  4  opcode
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- alu_out  output  WIDTH  result (low half for MUL)
- alu_out_hi  output  WIDTH  high half of product for MUL; 0 for every other op
- flag_z  output  1  alu_out == 0 (both halves == 0 for MUL)
- flag_c  output  1  carry out on ADD/INC; borrow on SUB/DEC/CMP; bit shifted out on SHL/SHR; 0 otherwise
- flag_n  output  1  MSB of alu_out (MSB of alu_out_hi for MUL)
- flag_v  output  1  signed overflow on ADD/SUB/INC/DEC; 0 otherwise
- busy  output  1  multiplier iterating

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0, state IDLE, internal registers 0.
  - in_ready rises on the first clk edge after deassertion.
- Opcodes (arithmetic modulo 2^WIDTH):
  - 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 NOT a
  - 6 SHL a by 1; 7 SHR a by 1, logical; 8 ROL a by 1; 9 ROR a by 1
  - A INC a; B DEC a
  - C CMP: result 1 if a<b unsigned, else 0
  - D EQ: result 1 if a==b, else 0
  - E MUL: unsigned a*b, multi-cycle
  - F PASS b
- Handshake:
  - Transfer occurs on the clk edge where valid && ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Output register holds alu_out, alu_out_hi, flags and out_valid stable until accepted.
  - out_valid clears on acceptance unless a new result is loaded on the same edge.
- State machine:
  - IDLE: on accept of opcodes other than E, result and flags are registered at that edge. Latency is 1 cycle. Throughput is 1 op/cycle while out_ready is high. Stay in IDLE.
  - IDLE: on accept of E, latch a (multiplicand) and b (multiplier), clear the accumulator, counter = WIDTH, go to MUL, busy=1.
  - MUL: each cycle, if multiplier LSB is 1, add multiplicand into the accumulator high half; shift {acc, multiplier} right by 1; decrement counter.
  - MUL: when counter reaches 0, go to LOAD.
  - LOAD: wait until !out_valid || out_ready. Then write the product to the output register, set out_valid, busy=0, return to IDLE.
  - MUL latency is WIDTH+1 cycles from accept to out_valid when the output is free.
- Boundaries and corner cases:
  - Inputs are ignored while busy or in LOAD; in_ready=0 there.
  - in_valid high with in_ready low causes no state change; the source must hold.
  - Same-edge pop and push: the old result is consumed, the new result is loaded, out_valid stays 1.
  - Reset mid-MUL: the operation is aborted and no result is produced.
  - MUL by 0 still takes WIDTH+1 cycles (no early termination). Result 0, flag_z=1.
  - out_ready high with out_valid low has no effect.

Test Plan (WIDTH=4 unless noted):
- Reset held, then released with in_valid=0 -> all outputs 0. in_ready=1 on the first edge after release. out_valid stays 0.
- a=7, b=A, instruction=0 (ADD), out_ready=1 -> next cycle alu_out=1, C=1, Z=0, N=0, V=0, alu_out_hi=0.
- a=7, b=A, instruction=1 (SUB) -> alu_out=D, C=1, N=1, V=1, Z=0.
- Sweep instruction 0..F back-to-back with a=7, b=A, out_ready=1 -> one result per cycle for non-MUL ops, each matching a reference model. Required values include SHL=E with C=0, ROR=B, CMP=1, EQ=0, PASS=A.
- a=7, b=A, MUL -> busy high for 4 cycles, in_ready=0 throughout. out_valid exactly 5 cycles after accept with alu_out=6, alu_out_hi=4. Repeat with WIDTH=8, a=FF, b=FF -> lo=01, hi=FE after 9 cycles.
- Backpressure and reset:
  - ADD result with out_ready=0 for 3 cycles -> outputs stable and in_ready=0. The next op is accepted on the same edge out_ready rises.
  - rst_n pulsed low during MUL cycle 2 -> outputs 0 immediately, no result emitted afterwards.

Source files
------------

// File: rtl/alu_pipe.sv
// Pipelined ALU: single-cycle ops return a registered result and flags; MUL
// iterates a shift-add multiplier and returns the full 2*WIDTH product.
module alu_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_LOAD} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             c;
    logic             n;
    logic             v;
  } alu_res_t;

  function automatic alu_res_t alu_op(input logic [3:0] op,
                                      input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y);
    alu_res_t       r;
    logic [WIDTH:0] ext;
    r   = '0;
    ext = '0;
    case (op)
      4'h0: begin
        ext   = {1'b0, x} + {1'b0, y};
        r.res = ext[MSB:0];
        r.c   = ext[WIDTH];
        r.v   = (x[MSB] == y[MSB]) && (r.res[MSB] != x[MSB]);
      end
      4'h1: begin
        // Top bit of the extended difference is the borrow.
        ext   = {1'b0, x} - {1'b0, y};
        r.res = ext[MSB:0];
        r.c   = ext[WIDTH];
        r.v   = (x[MSB] != y[MSB]) && (r.res[MSB] != x[MSB]);
      end
      4'h2: r.res = x & y;
      4'h3: r.res = x | y;
      4'h4: r.res = x ^ y;
      4'h5: r.res = ~x;
      4'h6: begin
        r.res = {x[MSB-1:0], 1'b0};
        r.c   = x[MSB];
      end
      4'h7: begin
        r.res = {1'b0, x[MSB:1]};
        r.c   = x[0];
      end
      4'h8: r.res = {x[MSB-1:0], x[MSB]};
      4'h9: r.res = {x[0], x[MSB:1]};
      4'hA: begin
        ext   = {1'b0, x} + (WIDTH+1)'(1);
        r.res = ext[MSB:0];
        r.c   = ext[WIDTH];
        r.v   = ~x[MSB] & r.res[MSB];
      end
      4'hB: begin
        ext   = {1'b0, x} - (WIDTH+1)'(1);
        r.res = ext[MSB:0];
        r.c   = ext[WIDTH];
        r.v   = x[MSB] & ~r.res[MSB];
      end
      4'hC: begin
        r.res = {{(WIDTH-1){1'b0}}, (x < y)};
        r.c   = (x < y);
      end
      4'hD: r.res = {{(WIDTH-1){1'b0}}, (x == y)};
      default: r.res = y;
    endcase
    r.z = (r.res == '0);
    r.n = r.res[MSB];
    return r;
  endfunction

  state_t           state_q;
  logic             rdy_en_q;
  logic [WIDTH-1:0] mcand_q, mplr_q, acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, out_valid_q;
  logic [WIDTH-1:0] res_q, hi_q;
  logic             z_q, c_q, n_q, v_q;

  logic             accept, ld_alu, start_mul, ld_mul;
  logic [WIDTH:0]   sum_d;
  alu_res_t         alu_d;

  always_comb begin
    in_ready  = rdy_en_q && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    accept    = in_valid && in_ready;
    ld_alu    = accept && (instruction != 4'hE);
    start_mul = accept && (instruction == 4'hE);
    ld_mul    = (state_q == S_LOAD) && (!out_valid_q || out_ready);
    sum_d     = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    alu_d     = alu_op(instruction, a, b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rdy_en_q    <= 1'b0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      hi_q        <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      // Multiplier control: {acc, mplr} shifts right once per iteration.
      case (state_q)
        S_IDLE: begin
          if (start_mul) begin
            mcand_q <= a;
            mplr_q  <= b;
            acc_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          acc_q  <= sum_d[WIDTH:1];
          mplr_q <= {sum_d[0], mplr_q[MSB:1]};
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (ld_mul) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Output register stage: holds until the consumer accepts.
      if (ld_alu) begin
        res_q       <= alu_d.res;
        hi_q        <= '0;
        z_q         <= alu_d.z;
        c_q         <= alu_d.c;
        n_q         <= alu_d.n;
        v_q         <= alu_d.v;
        out_valid_q <= 1'b1;
      end else if (ld_mul) begin
        res_q       <= mplr_q;
        hi_q        <= acc_q;
        z_q         <= (acc_q == '0) && (mplr_q == '0);
        c_q         <= 1'b0;
        n_q         <= acc_q[MSB];
        v_q         <= 1'b0;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_out    = res_q;
  assign alu_out_hi = hi_q;
  assign flag_z     = z_q;
  assign flag_c     = c_q;
  assign flag_n     = n_q;
  assign flag_v     = v_q;
  assign busy       = busy_q;

endmodule
